// File: rtl/mem_bus_unit_pkg.sv
// mem_bus_unit_pkg: shared default widths and FSM state type for the memory bus unit
package mem_bus_unit_pkg;
`include "mem_bus_defs.svh"
  localparam int DEF_DWIDTH = `MB_DWIDTH;
  localparam int DEF_AWIDTH = `MB_AWIDTH;
  localparam int DEF_TIMEOUT = `MB_TIMEOUT;
  typedef enum logic [1:0] {IDLE = `MB_ST_IDLE, REQ = `MB_ST_REQ, DONE = `MB_ST_DONE} state_t;
`include "mem_bus_undefs.svh"
endpackage

// File: rtl/mem_bus_defs.svh
// mem_bus_defs: default widths and FSM state encodings for the memory bus unit
`ifndef MEM_BUS_DEFS_SVH
`define MEM_BUS_DEFS_SVH
`define MB_DWIDTH 8
`define MB_AWIDTH 8
`define MB_TIMEOUT 15
`define MB_ST_IDLE 2'd0
`define MB_ST_REQ 2'd1
`define MB_ST_DONE 2'd2
`endif

// File: rtl/mem_bus_undefs.svh
// mem_bus_undefs: retracts every macro from mem_bus_defs so they stay local to their user
`undef MEM_BUS_DEFS_SVH
`undef MB_DWIDTH
`undef MB_AWIDTH
`undef MB_TIMEOUT
`undef MB_ST_IDLE
`undef MB_ST_REQ
`undef MB_ST_DONE

// File: rtl/mem_bus_unit_wait_counter.sv
// wait_counter: saturating ack-wait counter, done flags the edge on which it reaches TIMEOUT
module wait_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic inc,
  output logic done
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX = CW'(TIMEOUT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!res || clr) ? '0 : (inc && cnt != MAX) ? cnt + CW'(1) : cnt;
  assign done = inc && cnt == LAST;
endmodule

// File: rtl/mem_bus_unit.sv
// mem_bus_unit: single-transfer external bus master that stalls the sequencer until ack or timeout
module mem_bus_unit
  import mem_bus_unit_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              res,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic              stall,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              bus_req,
  output logic              bus_we,
  output logic [AWIDTH-1:0] bus_addr,
  output logic [DWIDTH-1:0] bus_wdata,
  input  logic [DWIDTH-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err,
  input  logic              err_clr
);
  state_t state;
  logic req, done;
  assign req = mem_rd || mem_wr;
  assign stall = res && (state == REQ || (state == IDLE && req));
  wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk (clk),
    .res (res),
    .clr (state == IDLE && req),
    .inc (state == REQ && !bus_ack),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (!res) begin
      state <= IDLE;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (err_clr) bus_err <= 1'b0;
      if (state == IDLE) begin
        if (req) begin
          state <= REQ;
          bus_req <= 1'b1;
          bus_we <= mem_wr;
          bus_addr <= addr;
          bus_wdata <= wdata;
        end
      end else if (state == REQ) begin
        if (bus_ack) begin
          state <= DONE;
          bus_req <= 1'b0;
          bus_we <= 1'b0;
          if (!bus_we) begin
            rd_data <= bus_rdata;
            rd_valid <= 1'b1;
          end
        end else if (done) begin
          state <= DONE;
          bus_req <= 1'b0;
          bus_we <= 1'b0;
          bus_err <= 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_unit.sv
// tb_mem_bus_unit: directed scenario checks for mem_bus_unit
module tb_mem_bus_unit;
  logic clk = 1'b0;
  logic res = 1'b0;
  logic mem_rd = 1'b0;
  logic mem_wr = 1'b0;
  logic bus_ack = 1'b0;
  logic err_clr = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] bus_rdata = '0;
  logic stall, rd_valid, bus_req, bus_we, bus_err;
  logic [7:0] rd_data, bus_addr, bus_wdata;
  int n_cmp = 0;
  int n_bad = 0;
  int s_cnt, r_cnt, w_cnt, v_cnt, v_idx;
  logic [7:0] a_seen, d_seen;
  mem_bus_unit #(.DWIDTH(8), .AWIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .res(res), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
    .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                     input int ack_wait, input logic [7:0] rdat, input logic hold, input logic clr,
                     input int n);
    int w = 0;
    s_cnt = 0; r_cnt = 0; w_cnt = 0; v_cnt = 0; v_idx = -1; a_seen = '0; d_seen = '0;
    mem_rd = rd; mem_wr = wr; addr = a; wdata = d; err_clr = clr;
    for (int i = 0; i < n; i++) begin
      bus_ack = bus_req && (w == ack_wait);
      bus_rdata = bus_ack ? rdat : 8'h00;
      #1;
      if (stall) s_cnt++;
      if (bus_req) begin
        r_cnt++;
        a_seen = bus_addr;
        d_seen = bus_wdata;
        if (bus_we) w_cnt++;
      end
      if (rd_valid) begin
        v_cnt++;
        v_idx = i;
      end
      w = bus_req ? w + 1 : 0;
      tick;
      if (!hold) begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
      end
    end
    bus_ack = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; err_clr = 1'b0;
  endtask
  task automatic test_reset;
    res = 1'b0; mem_rd = 1'b1; addr = 8'hFF; wdata = 8'hFF;
    tick;
    tick;
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_cmp++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, rd_data, rd_valid, bus_err} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h rd=%h rv=%b err=%b expected all 0",
               bus_req, bus_we, bus_addr, bus_wdata, rd_data, rd_valid, bus_err);
    end
    mem_rd = 1'b0;
    res = 1'b1;
    tick;
  endtask
  task automatic test_write;
    run(1'b0, 1'b1, 8'h3C, 8'hA5, 0, 8'h00, 1'b0, 1'b0, 6);
    n_cmp++;
    if (s_cnt !== 2) begin n_bad++; $display("FAIL write_stall_cycles: got %0d expected 2", s_cnt); end
    n_cmp++;
    if (w_cnt !== 1) begin n_bad++; $display("FAIL write_we_cycles: got %0d expected 1", w_cnt); end
    n_cmp++;
    if (a_seen !== 8'h3C) begin n_bad++; $display("FAIL write_addr: got %h expected 3c", a_seen); end
    n_cmp++;
    if (d_seen !== 8'hA5) begin n_bad++; $display("FAIL write_wdata: got %h expected a5", d_seen); end
    n_cmp++;
    if (v_cnt !== 0) begin n_bad++; $display("FAIL write_rd_valid: got %0d expected 0", v_cnt); end
  endtask
  task automatic test_read;
    run(1'b1, 1'b0, 8'h10, 8'h00, 3, 8'h5A, 1'b0, 1'b0, 8);
    n_cmp++;
    if (rd_data !== 8'h5A) begin n_bad++; $display("FAIL read_data: got %h expected 5a", rd_data); end
    n_cmp++;
    if (v_cnt !== 1) begin n_bad++; $display("FAIL read_valid_count: got %0d expected 1", v_cnt); end
    n_cmp++;
    if (v_idx !== 5) begin n_bad++; $display("FAIL read_valid_cycle: got %0d expected 5", v_idx); end
    n_cmp++;
    if (s_cnt !== 5) begin n_bad++; $display("FAIL read_stall_cycles: got %0d expected 5", s_cnt); end
    n_cmp++;
    if (r_cnt !== 4) begin n_bad++; $display("FAIL read_req_cycles: got %0d expected 4", r_cnt); end
    n_cmp++;
    if (w_cnt !== 0) begin n_bad++; $display("FAIL read_we_cycles: got %0d expected 0", w_cnt); end
  endtask
  task automatic test_conflict;
    run(1'b1, 1'b1, 8'h22, 8'h77, 0, 8'hC3, 1'b0, 1'b0, 6);
    n_cmp++;
    if (w_cnt !== 1) begin n_bad++; $display("FAIL conflict_we_cycles: got %0d expected 1", w_cnt); end
    n_cmp++;
    if (v_cnt !== 0) begin n_bad++; $display("FAIL conflict_rd_valid: got %0d expected 0", v_cnt); end
    n_cmp++;
    if (rd_data !== 8'h5A) begin n_bad++; $display("FAIL conflict_rd_data: got %h expected 5a", rd_data); end
    n_cmp++;
    if (d_seen !== 8'h77) begin n_bad++; $display("FAIL conflict_wdata: got %h expected 77", d_seen); end
  endtask
  task automatic test_timeout;
    run(1'b1, 1'b0, 8'h44, 8'h00, -1, 8'h00, 1'b0, 1'b0, 20);
    n_cmp++;
    if (r_cnt !== 15) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d expected 15", r_cnt); end
    n_cmp++;
    if (s_cnt !== 16) begin n_bad++; $display("FAIL timeout_stall_cycles: got %0d expected 16", s_cnt); end
    n_cmp++;
    if (bus_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b expected 1", bus_err); end
    n_cmp++;
    if (rd_data !== 8'h5A) begin n_bad++; $display("FAIL timeout_rd_data: got %h expected 5a", rd_data); end
    n_cmp++;
    if (v_cnt !== 0) begin n_bad++; $display("FAIL timeout_rd_valid: got %0d expected 0", v_cnt); end
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL timeout_idle_stall: got %b expected 0", stall); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    n_cmp++;
    if (bus_err !== 1'b0) begin n_bad++; $display("FAIL err_clr: got %b expected 0", bus_err); end
    run(1'b1, 1'b0, 8'h45, 8'h00, -1, 8'h00, 1'b0, 1'b1, 16);
    n_cmp++;
    if (bus_err !== 1'b1) begin n_bad++; $display("FAIL err_set_wins: got %b expected 1", bus_err); end
    err_clr = 1'b1;
    tick;
    tick;
    err_clr = 1'b0;
  endtask
  task automatic test_reset_mid_req;
    mem_rd = 1'b1; addr = 8'h55; wdata = 8'h66;
    tick;
    mem_rd = 1'b0;
    n_cmp++;
    if (bus_req !== 1'b1) begin n_bad++; $display("FAIL midreq_req_up: got %b expected 1", bus_req); end
    tick;
    res = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL midreq_stall_in_reset: got %b expected 0", stall); end
    tick;
    n_cmp++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, rd_data, rd_valid, bus_err} !== 29'd0) begin
      n_bad++;
      $display("FAIL midreq_outputs: got req=%b we=%b addr=%h wd=%h rd=%h rv=%b err=%b expected all 0",
               bus_req, bus_we, bus_addr, bus_wdata, rd_data, rd_valid, bus_err);
    end
    res = 1'b1; bus_ack = 1'b1; bus_rdata = 8'hEE;
    tick;
    #1;
    n_cmp++;
    if ({bus_req, rd_valid, rd_data} !== 10'd0) begin
      n_bad++;
      $display("FAIL late_ack: got req=%b rv=%b rd=%h expected 0 0 00", bus_req, rd_valid, rd_data);
    end
    tick;
    n_cmp++;
    if ({bus_req, rd_valid, rd_data, stall} !== 11'd0) begin
      n_bad++;
      $display("FAIL late_ack_2: got req=%b rv=%b rd=%h stall=%b expected all 0", bus_req, rd_valid, rd_data, stall);
    end
    bus_ack = 1'b0;
    tick;
  endtask
  task automatic test_back_to_back;
    run(1'b1, 1'b0, 8'h80, 8'h00, 0, 8'h3C, 1'b1, 1'b0, 6);
    n_cmp++;
    if (r_cnt !== 2) begin n_bad++; $display("FAIL b2b_req_cycles: got %0d expected 2", r_cnt); end
    n_cmp++;
    if (v_cnt !== 2) begin n_bad++; $display("FAIL b2b_rd_valid_count: got %0d expected 2", v_cnt); end
    n_cmp++;
    if (s_cnt !== 4) begin n_bad++; $display("FAIL b2b_stall_cycles: got %0d expected 4", s_cnt); end
    n_cmp++;
    if (v_idx !== 5) begin n_bad++; $display("FAIL b2b_last_valid_cycle: got %0d expected 5", v_idx); end
    n_cmp++;
    if (rd_data !== 8'h3C) begin n_bad++; $display("FAIL b2b_rd_data: got %h expected 3c", rd_data); end
  endtask
  initial begin
    test_reset;
    test_write;
    test_read;
    test_conflict;
    test_timeout;
    test_reset_mid_req;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_unit.md
MEM_BUS_UNIT -- requirements
Module: mem_bus_unit

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, giving the data bus width.
REQ-002 The block SHALL have parameter AWIDTH, default 8, giving the address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of wait cycles for bus_ack, with a legal range of 1..255.
REQ-004 Port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-005 Port res, input, 1 bit: reset; synchronous, active-low.
REQ-006 Port mem_rd, input, 1 bit: controller read request, sampled in IDLE.
REQ-007 Port mem_wr, input, 1 bit: controller write request (controller write_mem), sampled in IDLE.
REQ-008 Port addr, input, AWIDTH bits: address from the MAR.
REQ-009 Port wdata, input, DWIDTH bits: write data from the MDR.
REQ-010 Port stall, output, 1 bit: holds the microcode sequencer while a transfer is pending.
REQ-011 Port rd_data, output, DWIDTH bits: registered read data, routed to the MDR source mux.
REQ-012 Port rd_valid, output, 1 bit: one-cycle pulse, rd_data updated.
REQ-013 Port bus_req, output, 1 bit: external bus request.
REQ-014 Port bus_we, output, 1 bit: external write enable, qualified by bus_req.
REQ-015 Port bus_addr, output, AWIDTH bits: external address.
REQ-016 Port bus_wdata, output, DWIDTH bits: external write data.
REQ-017 Port bus_rdata, input, DWIDTH bits: external read data, valid when bus_ack=1.
REQ-018 Port bus_ack, input, 1 bit: external completion.
REQ-019 Port bus_err, output, 1 bit: sticky timeout flag.
REQ-020 Port err_clr, input, 1 bit: clears bus_err.

Function
REQ-021 The block SHALL implement the FSM states IDLE, REQ and DONE.
REQ-022 In IDLE with mem_wr=1 or mem_rd=1, the block SHALL latch addr, wdata and direction into registers, assert stall combinationally in the same cycle, and go to REQ on the next edge.
REQ-023 With mem_wr=1 and mem_rd=1 simultaneously, the block SHALL perform the write and ignore the read.
REQ-024 In REQ, the block SHALL assert bus_req=1; bus_addr, bus_we and bus_wdata SHALL be driven from the latched registers and held stable until exit.
REQ-025 In REQ with bus_ack=1, the block SHALL go to DONE; on a read, rd_data SHALL load bus_rdata on that same edge.
REQ-026 In REQ, the wait counter SHALL increment each cycle that bus_ack=0.
REQ-027 When the wait counter reaches TIMEOUT without ack, the block SHALL set bus_err=1, leave rd_data unchanged, and go to DONE.
REQ-028 In DONE, the block SHALL hold bus_req=0 and stall=0, and SHALL pulse rd_valid=1 for exactly one cycle, only for a successful read.
REQ-029 From DONE, the block SHALL unconditionally return to IDLE; requests presented in DONE SHALL be ignored, because the controller re-presents them.
REQ-030 stall SHALL equal 1 in REQ and in IDLE when a request is present, and 0 otherwise.
REQ-031 Best-case latency SHALL be 2 cycles with ack in the first REQ cycle: request, then REQ, then DONE.
REQ-032 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide, SHALL saturate rather than wrap, and SHALL clear on entry to REQ.
REQ-033 bus_err SHALL be sticky until err_clr=1; when a timeout and err_clr coincide, set SHALL win.
REQ-034 A bus_ack received outside REQ SHALL be ignored.

Reset
REQ-035 When res=0 at a clock edge, the block SHALL force: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rd_data=0, rd_valid=0, bus_err=0, counter=0.
REQ-036 While res=0, stall SHALL be 0.
REQ-037 A reset mid-REQ SHALL drop bus_req on the next edge with no rd_valid and no bus_err.

Structure
REQ-038 The FSM state encodings and the default widths SHALL live as defines in a shared memory-bus definitions include, paired with a matching undefs include.
REQ-039 The timeout counter SHALL be a sub-module named wait_counter, with inputs clr and inc and a done output.
REQ-040 The rest of the logic SHALL be implemented flat in one module.

Verification
REQ-041 Write test: mem_wr=1, addr=0x3C, wdata=0xA5, bus_ack on the 1st REQ cycle -> bus_we=1 and bus_addr=0x3C for one cycle, stall high 2 cycles, rd_valid=0.
REQ-042 Read test: mem_rd=1, addr=0x10, ack after 3 waits with bus_rdata=0x5A -> rd_data=0x5A, rd_valid a single pulse in DONE, stall high 5 cycles.
REQ-043 Conflict test: mem_rd=1 and mem_wr=1 together -> a write cycle only, rd_valid never set.
REQ-044 Timeout test: TIMEOUT=15, no ack -> bus_err=1 after 15 REQ cycles, rd_data unchanged, then IDLE; err_clr=1 -> bus_err=0 next cycle.
REQ-045 Reset test: res=0 on the 2nd REQ cycle -> all outputs at reset values next edge; a late bus_ack is ignored.
REQ-046 Back-to-back test: request held through DONE -> a new transfer starts from IDLE the following cycle, with exactly one rd_valid per transfer.
